// File: rtl/itch_msg_reasm.sv
// Reassembles one length-delimited ITCH message from a beat stream plus an optional
// overlap fragment, into a 2-entry ping-pong store with valid/ready output.
module itch_msg_reasm #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W/8,
  parameter int KEEP_LW       = $clog2(AXI_KEEP_W)+1,
  parameter int OV_DATA_W     = 48,
  parameter int OV_KEEP_LW    = 3,
  parameter int MSG_MAX_BYTES = 50,
  parameter int MSG_LEN_W     = 16,
  parameter int MSG_MAX_W     = $clog2(MSG_MAX_BYTES+1)
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       start_i,
  input  logic [MSG_LEN_W-1:0]       msg_len_i,
  input  logic [KEEP_LW-1:0]         len_i,
  input  logic [AXI_DATA_W-1:0]      data_i,
  input  logic                       ov_valid_i,
  input  logic [OV_KEEP_LW-1:0]      ov_len_i,
  input  logic [OV_DATA_W-1:0]       ov_data_i,
  output logic                       msg_v_o,
  input  logic                       msg_ready_i,
  output logic [MSG_MAX_W-1:0]       msg_len_o,
  output logic [7:0]                 msg_type_o,
  output logic [MSG_MAX_BYTES*8-1:0] msg_data_o,
  output logic                       err_len_o,
  output logic                       err_abort_o,
  output logic                       err_orphan_o
);
  localparam int OV_BYTES = OV_DATA_W/8;

  typedef enum logic [1:0] {IDLE, FILL, DROP, WAIT} state_t;

  state_t                              state, state_d;
  logic                                fsel, fsel_d, hold_v, hold_d, hsel;
  logic [MSG_LEN_W-1:0]                cnt, cnt_d, mlen_q, mlen_d;
  logic [1:0][MSG_MAX_W-1:0]           len_q;
  logic [1:0][MSG_MAX_BYTES-1:0][7:0]  mem;
  logic                                len_wr, done;
  logic                                err_len_d, err_abort_d, err_orphan_d;
  logic                                acc, pop, len_ok, wr_go;
  logic [OV_KEEP_LW-1:0]               ovl;
  logic [KEEP_LW:0]                    sum;
  logic [MSG_LEN_W-1:0]                mlen_w, base, cnt_nxt, cnt_sat;
  logic [MSG_MAX_BYTES-1:0]            wr_en;
  logic [MSG_MAX_BYTES-1:0][7:0]       wr_dat;
  logic [AXI_KEEP_W-1:0][7:0]          dby;
  logic [OV_BYTES-1:0][7:0]            oby;

  assign dby     = data_i;
  assign oby     = ov_data_i;
  assign ready_o = (state != WAIT);
  assign acc     = valid_i & ready_o;
  assign pop     = hold_v & msg_ready_i;
  assign hsel    = ~fsel;

  assign ovl     = ov_valid_i ? ov_len_i : '0;
  assign sum     = (KEEP_LW+1)'(ovl) + (KEEP_LW+1)'(len_i);
  // Compare at full length width so oversized lengths never alias onto the small counter
  assign mlen_w  = start_i ? msg_len_i : mlen_q;
  assign base    = start_i ? MSG_LEN_W'(ovl) : cnt;
  assign cnt_nxt = start_i ? MSG_LEN_W'(sum) : cnt + MSG_LEN_W'(len_i);
  assign cnt_sat = (cnt_nxt >= mlen_w) ? mlen_w : cnt_nxt;
  assign len_ok  = (msg_len_i != '0) && (msg_len_i <= MSG_LEN_W'(MSG_MAX_BYTES));
  assign wr_go   = acc & (start_i ? len_ok : (state == FILL));

  // Byte steering into the fill entry; bytes past the message length are dropped
  always_comb begin
    wr_en  = '0;
    wr_dat = '0;
    for (int b = 0; b < MSG_MAX_BYTES; b++) begin
      if (wr_go && (MSG_LEN_W'(b) < mlen_w)) begin
        for (int j = 0; j < AXI_KEEP_W; j++) begin
          if ((KEEP_LW'(j) < len_i) && (base + MSG_LEN_W'(j) == MSG_LEN_W'(b))) begin
            wr_en[b]  = 1'b1;
            wr_dat[b] = dby[j];
          end
        end
      end
    end
    for (int b = 0; b < OV_BYTES; b++) begin
      if (wr_go && start_i && (OV_KEEP_LW'(b) < ovl) && (MSG_LEN_W'(b) < mlen_w)) begin
        wr_en[b]  = 1'b1;
        wr_dat[b] = oby[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < MSG_MAX_BYTES; b++)
      if (wr_en[b]) mem[fsel][b] <= wr_dat[b];
  end

  always_comb begin
    state_d      = state;
    fsel_d       = fsel;
    hold_d       = hold_v;
    cnt_d        = cnt;
    mlen_d       = mlen_q;
    len_wr       = 1'b0;
    done         = 1'b0;
    err_len_d    = 1'b0;
    err_abort_d  = 1'b0;
    err_orphan_d = 1'b0;
    if (pop) hold_d = 1'b0;
    if (acc && start_i) begin
      err_abort_d = (state == FILL);
      mlen_d      = msg_len_i;
      cnt_d       = cnt_sat;
      if (!len_ok) begin
        err_len_d = 1'b1;
        state_d   = ((msg_len_i != '0) && (cnt_nxt < msg_len_i)) ? DROP : IDLE;
      end else if (cnt_nxt >= msg_len_i) begin
        done = 1'b1;
      end else begin
        state_d = FILL;
      end
    end else if (acc) begin
      case (state)
        IDLE: err_orphan_d = 1'b1;
        FILL: begin
          cnt_d = cnt_sat;
          if (cnt_nxt >= mlen_q) done = 1'b1;
        end
        DROP: begin
          cnt_d = cnt_sat;
          if (cnt_nxt >= mlen_q) state_d = IDLE;
        end
        default: ;
      endcase
    end
    if ((state == WAIT) && pop) begin
      fsel_d  = ~fsel;
      hold_d  = 1'b1;
      state_d = IDLE;
    end
    if (done) begin
      len_wr = 1'b1;
      if (!hold_v || pop) begin
        fsel_d  = ~fsel;
        hold_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      fsel         <= 1'b0;
      hold_v       <= 1'b0;
      cnt          <= '0;
      mlen_q       <= '0;
      len_q        <= '0;
      err_len_o    <= 1'b0;
      err_abort_o  <= 1'b0;
      err_orphan_o <= 1'b0;
    end else begin
      state        <= state_d;
      fsel         <= fsel_d;
      hold_v       <= hold_d;
      cnt          <= cnt_d;
      mlen_q       <= mlen_d;
      if (len_wr) len_q[fsel] <= MSG_MAX_W'(mlen_w);
      err_len_o    <= err_len_d;
      err_abort_o  <= err_abort_d;
      err_orphan_o <= err_orphan_d;
    end
  end

  // Storage is never cleared, so the hold entry is masked by its length
  always_comb begin
    msg_data_o = '0;
    for (int b = 0; b < MSG_MAX_BYTES; b++)
      if (MSG_MAX_W'(b) < len_q[hsel]) msg_data_o[b*8 +: 8] = mem[hsel][b];
  end

  assign msg_type_o = msg_data_o[7:0];
  assign msg_len_o  = len_q[hsel];
  assign msg_v_o    = hold_v;

endmodule

// File: tb/tb_itch_msg_reasm.sv
// Scoreboard bench for itch_msg_reasm: stimulus pushes expected messages, a
// negedge monitor pops and compares on every output transfer.
module tb_itch_msg_reasm;
  localparam int DW = 400;

  logic             clk = 1'b0;
  logic             nreset;
  logic             valid_i, ready_o, start_i;
  logic [15:0]      msg_len_i;
  logic [3:0]       len_i;
  logic [63:0]      data_i;
  logic             ov_valid_i;
  logic [2:0]       ov_len_i;
  logic [47:0]      ov_data_i;
  logic             msg_v_o, msg_ready_i;
  logic [5:0]       msg_len_o;
  logic [7:0]       msg_type_o;
  logic [DW-1:0]    msg_data_o;
  logic             err_len_o, err_abort_o, err_orphan_o;

  itch_msg_reasm dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
    .start_i(start_i), .msg_len_i(msg_len_i), .len_i(len_i), .data_i(data_i),
    .ov_valid_i(ov_valid_i), .ov_len_i(ov_len_i), .ov_data_i(ov_data_i),
    .msg_v_o(msg_v_o), .msg_ready_i(msg_ready_i), .msg_len_o(msg_len_o),
    .msg_type_o(msg_type_o), .msg_data_o(msg_data_o), .err_len_o(err_len_o),
    .err_abort_o(err_abort_o), .err_orphan_o(err_orphan_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            len;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int n_len = 0, n_abort = 0, n_orphan = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: error pulse counting, stall stability and transfer comparison
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (err_len_o)    n_len++;
      if (err_abort_o)  n_abort++;
      if (err_orphan_o) n_orphan++;
      if (msg_v_o && !msg_ready_i && q.size() > 0) begin
        chk("stall_len",  DW'(msg_len_o),  DW'(q[0].len));
        chk("stall_data", msg_data_o,      q[0].data);
      end
      if (msg_v_o && msg_ready_i) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_msg act=len %0d exp=none", msg_len_o);
        end else begin
          e = q.pop_front();
          chk("msg_len",  DW'(msg_len_o),  DW'(e.len));
          chk("msg_type", DW'(msg_type_o), DW'(e.data[7:0]));
          chk("msg_data", msg_data_o,      e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit st, input int ml, input bit ovv, input int ovl,
                      input int n, input logic [63:0] d, input logic [47:0] ov);
    int t = 0;
    valid_i = 1'b1; start_i = st; msg_len_i = 16'(ml);
    ov_valid_i = ovv; ov_len_i = 3'(ovl); ov_data_i = ov;
    len_i = 4'(n); data_i = d;
    while (!ready_o && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t == 1000) begin
      checks++; errors++;
      $display("FAIL ready_timeout act=0 exp=1");
    end
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0; ov_valid_i = 1'b0;
  endtask

  // Byte k of a message is seed+7k; overlap carries the first ovl bytes
  task automatic send_msg(input int seed, input int mlen, input int ovl, input int total, input bit push);
    logic [7:0]  by [64];
    logic [63:0] d;
    logic [47:0] ov;
    exp_t        e;
    int          pos, n;
    bit          first;
    for (int k = 0; k < 64; k++) by[k] = 8'(seed + 7*k);
    if (push) begin
      e.len = mlen; e.data = '0;
      for (int k = 0; k < mlen; k++) e.data[k*8 +: 8] = by[k];
      q.push_back(e);
    end
    ov = '0;
    for (int k = 0; k < ovl; k++) ov[k*8 +: 8] = by[k];
    pos = ovl; first = 1'b1;
    do begin
      n = total - pos; if (n > 8) n = 8;
      d = '0;
      for (int k = 0; k < n; k++) d[k*8 +: 8] = by[pos+k];
      beat(first, mlen, ovl > 0, ovl, n, d, ov);
      first = 1'b0; pos += n;
    end while (pos < total);
  endtask

  initial begin
    nreset = 1'b0; valid_i = 1'b0; start_i = 1'b0; msg_len_i = '0; len_i = '0;
    data_i = '0; ov_valid_i = 1'b0; ov_len_i = '0; ov_data_i = '0; msg_ready_i = 1'b1;
    #12;
    chk("rst_msg_v",  DW'(msg_v_o),      DW'(0));
    chk("rst_ready",  DW'(ready_o),      DW'(1));
    chk("rst_errlen", DW'(err_len_o),    DW'(0));
    chk("rst_errab",  DW'(err_abort_o),  DW'(0));
    chk("rst_erorph", DW'(err_orphan_o), DW'(0));
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;

    // 36-byte message, 8,8,8,8,4
    send_msg(8'h10, 36, 0, 36, 1);
    chk("t1_latency", DW'(msg_v_o),   DW'(1));
    chk("t1_len",     DW'(msg_len_o), DW'(36));
    chk("t1_ready",   DW'(ready_o),   DW'(1));

    // overlap 6 + data 8 completes on the start beat; 0x40+7k
    send_msg(8'h40, 14, 6, 14, 1);
    chk("t2_latency", DW'(msg_v_o),    DW'(1));
    chk("t2_type",    DW'(msg_type_o), DW'(8'h40));
    chk("t2_byte6",   DW'(msg_data_o[55:48]), DW'(8'h6A));

    // excess bytes of the completing beat are discarded
    send_msg(8'h55, 13, 0, 16, 1);
    chk("t3_byte13",  DW'(msg_data_o[111:104]), DW'(0));
    // largest legal length, then one past it
    send_msg(8'h60, 50, 0, 50, 1);
    send_msg(8'h70, 51, 0, 51, 0);
    idle(3);
    chk("t4_errlen", DW'(n_len), DW'(1));

    // backpressure: two 11-byte messages
    msg_ready_i = 1'b0;
    send_msg(8'h21, 11, 0, 11, 1);
    chk("bp_first_v", DW'(msg_v_o), DW'(1));
    send_msg(8'h33, 11, 0, 11, 1);
    chk("bp_wait_ready", DW'(ready_o), DW'(0));
    idle(2);
    chk("bp_hold_type", DW'(msg_type_o), DW'(8'h21));
    msg_ready_i = 1'b1;
    idle(1);
    chk("bp_ready_back", DW'(ready_o),    DW'(1));
    chk("bp_second_v",   DW'(msg_v_o),    DW'(1));
    chk("bp_second_typ", DW'(msg_type_o), DW'(8'h33));
    idle(1);
    chk("bp_drained",    DW'(msg_v_o),    DW'(0));

    // abort: 2 beats of a 30-byte message then a 9-byte message
    send_msg(8'h80, 30, 0, 16, 0);
    send_msg(8'h88, 9, 0, 9, 1);
    idle(3);
    chk("ab_count", DW'(n_abort), DW'(1));

    // oversized length consumed silently, next start accepted
    send_msg(8'h11, 60, 0, 64, 0);
    send_msg(8'h90, 5, 0, 5, 1);
    idle(3);
    chk("bl_errlen", DW'(n_len), DW'(2));
    // zero length stays IDLE, so the next non-start beat is an orphan
    beat(1, 0, 0, 0, 0, 64'h0, 48'h0);
    beat(0, 0, 0, 0, 3, 64'h0000_0000_00AB_CDEF, 48'h0);
    idle(3);
    chk("z_errlen", DW'(n_len),    DW'(3));
    chk("z_orphan", DW'(n_orphan), DW'(1));
    chk("z_abort",  DW'(n_abort),  DW'(1));

    // reset mid-fill with a message held
    msg_ready_i = 1'b0;
    send_msg(8'hA0, 5, 0, 5, 1);
    chk("rm_held", DW'(msg_v_o), DW'(1));
    send_msg(8'hB0, 20, 0, 16, 0);
    #2 nreset = 1'b0;
    #1;
    chk("rm_msg_v", DW'(msg_v_o), DW'(0));
    chk("rm_ready", DW'(ready_o), DW'(1));
    q.delete();
    msg_ready_i = 1'b1;
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;
    beat(0, 0, 0, 0, 8, 64'h0102_0304_0506_0708, 48'h0);
    idle(3);
    chk("rm_orphan", DW'(n_orphan), DW'(2));
    chk("rm_nomsg",  DW'(msg_v_o),  DW'(0));

    idle(2);
    chk("queue_empty", DW'(q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
